// File: rtl/param_sync_fifo.sv
// Single-clock show-ahead FIFO with arbitrary depth, occupancy level, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and synchronous flush.
module param_sync_fifo #(
   parameter int WIDTH         = 16,
   parameter int DEPTH         = 16,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 1,
   localparam int LW           = $clog2(DEPTH + 1),
   localparam int PW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] write_data,
   input  logic             pop,
   output logic [WIDTH-1:0] read_data,
   output logic             empty,
   output logic             full,
   output logic [LW-1:0]    level,
   output logic             almost_full,
   output logic             almost_empty,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
   localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_THRESH);
   localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_THRESH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [LW-1:0]    level_r;
   logic             overflow_r;
   logic             underflow_r;

   logic             empty_s;
   logic             full_s;
   logic             pop_ok_s;
   logic             push_ok_s;
   logic [PW-1:0]    wr_ptr_nxt_s;
   logic [PW-1:0]    rd_ptr_nxt_s;

   // Flag decode and accept rules; a clear cycle accepts nothing.
   always_comb begin
      empty_s   = (level_r == {LW{1'b0}});
      full_s    = (level_r == DEPTH_L);
      pop_ok_s  = pop & ~empty_s & ~clear;
      push_ok_s = push & (~full_s | (pop & ~empty_s)) & ~clear;
      if (wr_ptr_r == LAST_PTR) begin
         wr_ptr_nxt_s = {PW{1'b0}};
      end else begin
         wr_ptr_nxt_s = wr_ptr_r + PW'(1);
      end
      if (rd_ptr_r == LAST_PTR) begin
         rd_ptr_nxt_s = {PW{1'b0}};
      end else begin
         rd_ptr_nxt_s = rd_ptr_r + PW'(1);
      end
   end

   // Storage array; intentionally not reset, only written on an accepted push.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= write_data;
      end
   end

   // Pointers, occupancy and sticky error flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r    <= {PW{1'b0}};
         rd_ptr_r    <= {PW{1'b0}};
         level_r     <= {LW{1'b0}};
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else if (clear) begin
         wr_ptr_r    <= {PW{1'b0}};
         rd_ptr_r    <= {PW{1'b0}};
         level_r     <= {LW{1'b0}};
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_nxt_s;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_nxt_s;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   level_r <= level_r + LW'(1);
            2'b01:   level_r <= level_r - LW'(1);
            default: level_r <= level_r;
         endcase
         overflow_r  <= overflow_r | (push & ~push_ok_s);
         underflow_r <= underflow_r | (pop & empty_s);
      end
   end

   // Show-ahead head word, forced to zero while empty so stale entries never leak.
   always_comb begin
      if (empty_s) begin
         read_data = {WIDTH{1'b0}};
      end else begin
         read_data = mem_r[rd_ptr_r];
      end
   end

   assign empty        = empty_s;
   assign full         = full_s;
   assign level        = level_r;
   assign almost_full  = (level_r >= AFULL_L);
   assign almost_empty = (level_r <= AEMPTY_L);
   assign overflow     = overflow_r;
   assign underflow    = underflow_r;

endmodule
